// File: rtl/rf_pkg.sv
// Shared constants and the byte-lane merge used by both the storage update and the read bypass.
package rf_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_DEPTH      = 8;

  // Widest word the merge helper handles; narrower words are zero-extended in and cast back out.
  localparam int RF_MAX_WIDTH  = 256;
  localparam int RF_MAX_BYTES  = RF_MAX_WIDTH / 8;

  function automatic logic [RF_MAX_WIDTH-1:0] byte_merge(
    input logic [RF_MAX_WIDTH-1:0] old_word,
    input logic [RF_MAX_WIDTH-1:0] new_word,
    input logic [RF_MAX_BYTES-1:0] be
  );
    logic [RF_MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int k = 0; k < RF_MAX_BYTES; k++) begin
      if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range/zero-register check, clear, write-to-read bypass, output flop.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int DEPTH      = RF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ZERO_REG   = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_clr,
  input  logic                    i_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH-1:0]   i_mem [DEPTH],
  output logic [DATA_WIDTH-1:0]   o_rd_data
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic                  w_out_of_range;
  logic                  w_is_zero_reg;
  logic                  w_bypass;
  logic [DATA_WIDTH-1:0] w_stored;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_next;
  logic [DATA_WIDTH-1:0] r_rd_data;

  assign w_out_of_range = ({1'b0, i_rd_addr} >= LP_DEPTH);
  assign w_is_zero_reg  = (ZERO_REG != 0) && (i_rd_addr == '0);
  assign w_bypass       = i_we && (i_wr_addr == i_rd_addr);

  // Explicit compare mux so a non-power-of-two DEPTH never indexes past the array.
  always_comb begin
    w_stored = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_addr == ADDR_WIDTH'(i)) w_stored = i_mem[i];
    end
  end

  assign w_merged = DATA_WIDTH'(byte_merge(RF_MAX_WIDTH'(w_stored),
                                           RF_MAX_WIDTH'(i_wr_data),
                                           RF_MAX_BYTES'(i_wr_be)));

  always_comb begin
    w_next = w_stored;
    if (w_out_of_range || w_is_zero_reg) begin
      w_next = '0;
    end else if (i_clr) begin
      w_next = '0;
    end else if (w_bypass) begin
      w_next = w_merged;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= w_next;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/register_file_2r1w.sv
// DEPTH x DATA_WIDTH flop-based register file: one byte-enabled write port, two registered read ports.
module register_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int DEPTH      = RF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ZERO_REG   = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_clr,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_rd_en0,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr0,
  output logic [DATA_WIDTH-1:0]   o_rd_data0,
  input  logic                    i_rd_en1,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr1,
  output logic [DATA_WIDTH-1:0]   o_rd_data1,
  output logic [DEPTH-1:0]        o_valid
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DATA_WIDTH-1:0] w_wr_old;
  logic [DATA_WIDTH-1:0] w_wr_word;
  logic                  w_wr_ok;

  // Writes outside the array or to a hardwired zero register leave storage and valid untouched.
  assign w_wr_ok = i_we && !i_clr
                && ({1'b0, i_wr_addr} < LP_DEPTH)
                && !((ZERO_REG != 0) && (i_wr_addr == '0));

  always_comb begin
    w_wr_old = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_wr_addr == ADDR_WIDTH'(i)) w_wr_old = r_mem[i];
    end
  end

  assign w_wr_word = DATA_WIDTH'(byte_merge(RF_MAX_WIDTH'(w_wr_old),
                                            RF_MAX_WIDTH'(i_wr_data),
                                            RF_MAX_BYTES'(i_wr_be)));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_addr == ADDR_WIDTH'(i)) begin
          r_mem[i]   <= w_wr_word;
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  assign o_valid = r_valid;

  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_rd_port0 (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clr      (i_clr),
    .i_rd_en    (i_rd_en0),
    .i_rd_addr  (i_rd_addr0),
    .i_we       (i_we),
    .i_wr_addr  (i_wr_addr),
    .i_wr_be    (i_wr_be),
    .i_wr_data  (i_wr_data),
    .i_mem      (r_mem),
    .o_rd_data  (o_rd_data0)
  );

  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_rd_port1 (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clr      (i_clr),
    .i_rd_en    (i_rd_en1),
    .i_rd_addr  (i_rd_addr1),
    .i_we       (i_we),
    .i_wr_addr  (i_wr_addr),
    .i_wr_be    (i_wr_be),
    .i_wr_data  (i_wr_data),
    .i_mem      (r_mem),
    .o_rd_data  (o_rd_data1)
  );

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised register file: DEPTH words of DATA_WIDTH bits, one address-decoded write port with byte enables, two synchronous read ports.
- Generalises the fixed 8x32 one-hot-enable register bank: binary write address replaces the one-hot enable, and muxed read ports replace per-register outputs.
- Adds write-to-read bypass, synchronous clear, an optional hardwired zero register and a per-register written/valid map.
- Sits between the datapath ALU/writeback and operand fetch.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
DEPTH, 8, number of registers (need not be a power of 2, min 2)
ADDR_WIDTH, $clog2(DEPTH), address width
ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of all registers and valid map
we  in  1  write enable
wr_addr  in  ADDR_WIDTH  write address
wr_be  in  DATA_WIDTH/8  byte enables for write
wr_data  in  DATA_WIDTH  write data
rd_en0  in  1  read port 0 enable
rd_addr0  in  ADDR_WIDTH  read port 0 address
rd_data0  out  DATA_WIDTH  read port 0 data (registered)
rd_en1  in  1  read port 1 enable
rd_addr1  in  ADDR_WIDTH  read port 1 address
rd_data1  out  DATA_WIDTH  read port 1 data (registered)
valid  out  DEPTH  bit i = register i written since last reset/clr

Behaviour:
- Reset (reset_n=0, asynchronous): all registers, rd_data0, rd_data1 and valid go to 0 immediately and hold until reset_n rises.
- Write: on a rising edge with we=1 and clr=0, register[wr_addr] byte k <= wr_data byte k for each wr_be[k]=1; other bytes unchanged. valid[wr_addr] <= 1 whenever we=1, even if wr_be=0.
- Ignored writes: wr_addr >= DEPTH, or ZERO_REG=1 and wr_addr=0. Neither storage nor valid changes.
- Clear: clr=1 on a rising edge zeroes every register and valid. clr beats a concurrent we; the write is dropped.
- Read latency is 1 cycle: with rd_enN=1 at edge t, rd_dataN holds the data from edge t until the next enabled read. With rd_enN=0, rd_dataN holds its value.
- Read data rules, in priority order:
  - Returns 0 if rd_addrN >= DEPTH, or ZERO_REG=1 and rd_addrN=0.
  - If clr=1 in the same cycle, returns 0.
  - Bypass: if we=1 and wr_addr=rd_addrN in the same cycle, returns the post-write merged word (old bytes where wr_be=0, new bytes where wr_be=1), never the stale word.
  - Otherwise returns the stored word.
- Both read ports are independent. Both may read the same address, including the bypassed one.
- No state machine. Storage is DEPTH x DATA_WIDTH flops, not inferred RAM, so the asynchronous reset applies to all of it.
- Reset mid-operation: an in-flight write or read in that cycle is discarded. Outputs read 0 on the first enabled read after reset_n rises.

Decomposition:
- Shared package rf_pkg:
  - default constants RF_DATA_WIDTH=32, RF_DEPTH=8
  - function byte_merge(old, new, be) returning the merged word, used by both the storage update and the bypass path
- One natural sub-module, rf_read_port: address range/zero check, bypass compare, output register. Instantiated twice.

Test Plan:
1. Reset then read: reset_n=0 for 9 ns, release, rd_en0=1, rd_addr0=3 -> rd_data0=0x00000000 and valid=8'h00.
2. Write then read: we=1, wr_addr=2, wr_be=4'hF, wr_data=0x00FF00FF. Next cycle rd_addr0=2 -> rd_data0=0x00FF00FF one cycle later, valid=8'h04.
3. Byte-masked bypass: reg5=0x11223344. In one cycle we=1, wr_addr=5, wr_be=4'b0101, wr_data=0xAABBCCDD, rd_addr1=5 -> next-cycle rd_data1=0x11BB33DD, and reg5 reads 0x11BB33DD afterwards.
4. Clear vs write: registers 0-7 written with 0x00FF00FF; clr=1 and we=1 (wr_addr=1, data 0xDEADBEEF) in the same cycle -> valid=0, all reads return 0, reg1 reads 0.
5. ZERO_REG=1, DEPTH=6: write 0x12345678 to addr 0 and addr 6 -> reads of addr 0 and addr 6 return 0, valid=6'h00. Write to addr 5 -> valid=6'h20.
6. Async reset mid-write: assert reset_n=0 between edges with we=1 pending -> rd_data0/rd_data1/valid go to 0 without a clock edge, and the pending write never appears.
